// File: rtl/chacha20_keystream_xor.sv
// chacha20_keystream_xor
// Buffers serialised ChaCha20 keystream words in a FIFO, requests one block at a
// time from the block function, and XORs each keystream word with one incoming
// data word under valid/ready. Keystream words that turn up while no block is
// outstanding, or while the FIFO cannot take them, are dropped and flagged.
module chacha20_keystream_xor #(
  parameter int WORD_W      = 32,
  parameter int DEPTH       = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  blk_req,
  input  logic [WORD_W-1:0]     ks_data,
  input  logic                  ks_valid,
  output logic                  ks_ready,
  input  logic [WORD_W-1:0]     in_data,
  input  logic [WORD_W/8-1:0]   in_keep,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic [WORD_W/8-1:0]   out_keep,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ks_err,
  output logic                  busy
);
  localparam int KW = WORD_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       w_count;
  logic [AW:0]       w_count_nxt;
  logic [AW:0]       w_free;
  logic              w_full;
  logic              w_empty;
  logic              r_outstanding;
  logic [CW-1:0]     r_ks_cnt;
  logic              r_blk_req;
  logic              r_ks_ready;
  logic              w_ks_ready_nxt;
  logic              r_ks_err;
  logic [WORD_W-1:0] r_out_data;
  logic [KW-1:0]     r_out_keep;
  logic              r_out_last;
  logic              r_out_valid;
  logic              w_ks_fire;
  logic              w_ks_bad;
  logic              w_push;
  logic              w_pop;
  logic              w_req;
  logic              w_wrap;
  logic              w_drain_done;

  // Expand per-byte enables into a word-wide mask
  function automatic logic [WORD_W-1:0] keep_to_mask(input logic [KW-1:0] keep);
    logic [WORD_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < KW; i++) begin
      mask[i*8 +: 8] = {8{keep[i]}};
    end
    return mask;
  endfunction

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == (AW+1)'(DEPTH));
  assign w_empty      = (w_count == '0);
  assign w_free       = (AW+1)'(DEPTH) - w_count;
  // A keystream word is only taken when a block is pending and we said ready
  assign w_ks_fire    = ks_valid & r_ks_ready & r_outstanding;
  assign w_ks_bad     = ks_valid & (~r_ks_ready | ~r_outstanding);
  assign w_push       = w_ks_fire & (r_state == S_RUN) & ~w_full;
  assign w_wrap       = w_ks_fire & (r_ks_cnt == CW'(BLOCK_WORDS - 1));
  assign w_req        = (r_state == S_RUN) & ~r_outstanding & (w_free >= (AW+1)'(BLOCK_WORDS));
  assign w_drain_done = (r_state == S_DRAIN) & ~r_outstanding;
  assign in_ready     = (r_state == S_RUN) & ~w_empty & (~r_out_valid | out_ready);
  assign w_pop        = in_valid & in_ready;
  assign w_count_nxt  = w_drain_done ? '0 : (w_count + (AW+1)'(w_push) - (AW+1)'(w_pop));

  assign blk_req   = r_blk_req;
  assign ks_ready  = r_ks_ready;
  assign ks_err    = r_ks_err;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);

  // Next-state logic for the message FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN; else w_state_nxt = S_IDLE;
      S_RUN:   if (w_pop && in_last) w_state_nxt = S_DRAIN; else w_state_nxt = S_RUN;
      S_DRAIN: if (!r_outstanding) w_state_nxt = S_IDLE; else w_state_nxt = S_DRAIN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ks_ready is registered, so precompute what it must be next cycle
  always_comb begin
    w_ks_ready_nxt = 1'b0;
    case (w_state_nxt)
      S_RUN:   w_ks_ready_nxt = (w_count_nxt != (AW+1)'(DEPTH));
      S_DRAIN: w_ks_ready_nxt = 1'b1;
      S_IDLE:  w_ks_ready_nxt = 1'b1;
      default: w_ks_ready_nxt = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FIFO pointers; emptied wholesale when a drained message returns to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_drain_done) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (AW+1)'(w_push);
      r_rd_ptr <= r_rd_ptr + (AW+1)'(w_pop);
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= ks_data;
  end

  // Block request handshake, keystream word counter, ready and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= 1'b0;
      r_ks_cnt      <= '0;
      r_blk_req     <= 1'b0;
      r_ks_ready    <= 1'b0;
      r_ks_err      <= 1'b0;
    end else begin
      r_blk_req  <= w_req;
      r_ks_ready <= w_ks_ready_nxt;
      if (w_ks_bad) r_ks_err <= 1'b1;
      if (w_req) begin
        r_outstanding <= 1'b1;
      end else if (w_wrap) begin
        r_outstanding <= 1'b0;
      end
      if (w_wrap) begin
        r_ks_cnt <= '0;
      end else if (w_ks_fire) begin
        r_ks_cnt <= r_ks_cnt + CW'(1);
      end
    end
  end

  // Output stage: capture the masked XOR on transfer, hold until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_data  <= (in_data ^ r_mem[r_rd_ptr[AW-1:0]]) & keep_to_mask(in_keep);
      r_out_keep  <= in_keep;
      r_out_last  <= in_last;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
